// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit
//   Iterative radix-2 RV64M multiply/divide unit for the EX stage. One op at
//   a time: shift-add multiply and restoring divide on operand magnitudes,
//   one bit per cycle, with the sign applied when the result is delivered.
//   Divide-by-zero and signed overflow are resolved when the op is accepted,
//   and go straight to DONE.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   valid_i         M-ext op present in EX this cycle
//   op_i            operation code (13..15 treated as MUL)
//   src1_i, src2_i  rs1 / rs2 operands
//   flush_i         abort the current op; return to IDLE next cycle
//   stall_req_o     hold the upstream pipeline (combinational)
//   result_valid_o  one-cycle pulse in the DONE cycle
//   result_o        result; holds its last value outside DONE
module ex_mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_MULW   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    state_t              state, state_nxt;
    logic [3:0]          op_r;
    logic                is_div_r;
    logic                neg_res;     // negate product / quotient
    logic                neg_rem;     // negate remainder (dividend sign)
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     a_r;         // multiplier (mul) or dividend/quotient (div)
    logic [2*XLEN-1:0]   b_r;         // shifted multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0]   acc;         // product (mul) or remainder in low half (div)
    logic [XLEN-1:0]     last_res;

    // Accept-time decode
    logic [3:0]          op_eff;
    logic                is_w, is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic                div0, ovf, accept;
    logic [XLEN-1:0]     xa, xb, mag_a, mag_b, min_val;

    always_comb begin
        op_eff  = (op_i > OP_REMUW) ? OP_MUL : op_i;
        is_w    = (op_eff >= OP_MULW);
        is_div  = ((op_eff >= OP_DIV) && (op_eff <= OP_REMU)) || (op_eff >= OP_DIVW);
        sgn_a   = op_eff inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sgn_b   = op_eff inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        xa      = is_w ? (sgn_a ? sext_w(src1_i[HALF-1:0]) : {{HALF{1'b0}}, src1_i[HALF-1:0]})
                       : src1_i;
        xb      = is_w ? (sgn_b ? sext_w(src2_i[HALF-1:0]) : {{HALF{1'b0}}, src2_i[HALF-1:0]})
                       : src2_i;
        neg_a   = sgn_a & xa[XLEN-1];
        neg_b   = sgn_b & xb[XLEN-1];
        mag_a   = cneg(xa, neg_a);
        mag_b   = cneg(xb, neg_b);
        min_val = is_w ? sext_w({1'b1, {(HALF-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
        div0    = is_div && (xb == '0);
        ovf     = is_div && sgn_a && (xa == min_val) && (&xb);
        accept  = valid_i & ~flush_i;
    end

    // One iteration step and result sign fix-up
    logic [2*XLEN-1:0]   mul_sum, mul_res;
    logic [XLEN:0]       div_shift;
    logic [XLEN-1:0]     div_diff, q_res, r_res, fin;
    logic                div_ge;

    always_comb begin
        mul_sum   = acc + b_r;
        div_shift = {acc[XLEN-1:0], a_r[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_r[XLEN-1:0]});
        // Only used when div_ge, where the true difference is below the divisor
        div_diff  = div_shift[XLEN-1:0] - b_r[XLEN-1:0];
        mul_res   = cneg2(acc, neg_res);
        q_res     = cneg(a_r, neg_res);
        r_res     = cneg(acc[XLEN-1:0], neg_rem);
        case (op_r)
            OP_MULH, OP_MULHSU, OP_MULHU: fin = mul_res[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin = q_res;
            OP_REM, OP_REMU:              fin = r_res;
            OP_MULW:                      fin = sext_w(mul_res[HALF-1:0]);
            OP_DIVW, OP_DIVUW:            fin = sext_w(q_res[HALF-1:0]);
            OP_REMW, OP_REMUW:            fin = sext_w(r_res[HALF-1:0]);
            default:                      fin = mul_res[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        case (state)
            IDLE: if (accept) begin
                stall_req_o = 1'b1;
                state_nxt   = (div0 | ovf) ? DONE : CALC;
            end
            CALC: begin
                stall_req_o = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt      = IDLE;
            stall_req_o    = 1'b0;
            result_valid_o = 1'b0;
        end
        result_o = (state == DONE) ? fin : last_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            is_div_r <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            last_res <= '0;
        end else begin
            if (state == IDLE && accept) begin
                op_r     <= op_eff;
                is_div_r <= is_div;
                // Special cases preload magnitudes so the normal sign fix-up
                // yields -1 / dividend (div by zero) or MIN / 0 (overflow).
                neg_res  <= ~div0 & (neg_a ^ neg_b);
                neg_rem  <= neg_a;
                cnt      <= is_w ? CW'(HALF) : CW'(XLEN);
                b_r      <= {{XLEN{1'b0}}, mag_b};
                acc      <= div0 ? {{XLEN{1'b0}}, mag_a} : '0;
                if (div0)
                    a_r <= '1;
                else if (is_div && is_w && !ovf)
                    a_r <= {mag_a[HALF-1:0], {HALF{1'b0}}};  // dividend MSB-aligned for 32 steps
                else
                    a_r <= mag_a;
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
                if (is_div_r) begin
                    acc[XLEN-1:0] <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    a_r           <= {a_r[XLEN-2:0], div_ge};
                end else begin
                    if (a_r[0]) acc <= mul_sum;
                    b_r <= b_r << 1;
                    a_r <= a_r >> 1;
                end
            end
            if (state == DONE) last_res <= fin;
        end
    end
endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Testbench for ex_mul_div_unit: directed vectors with hand-computed results.
// Stimulus pushes the expected result and delivery cycle into a queue; an
// independent monitor pops and compares on every result_valid_o pulse.
module tb_ex_mul_div_unit;
    localparam logic [3:0] MUL = 4'd0, MULH = 4'd1, MULHSU = 4'd2, MULHU = 4'd3;
    localparam logic [3:0] DIV = 4'd4, DIVU = 4'd5, REM = 4'd6, REMU = 4'd7;
    localparam logic [3:0] MULW = 4'd8, DIVW = 4'd9, DIVUW = 4'd10, REMW = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] src1 = '0, src2 = '0;
    logic        flush = 1'b0;
    logic        stall, result_valid;
    logic [63:0] result;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;
    exp_t sbq[$];

    ex_mul_div_unit dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid),
        .op_i           (op),
        .src1_i         (src1),
        .src2_i         (src2),
        .flush_i        (flush),
        .stall_req_o    (stall),
        .result_valid_o (result_valid),
        .result_o       (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: compare every delivered result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && result_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got result 0x%016h with no op pending", result);
            end else begin
                e = sbq.pop_front();
                check("result", result, e.val);
                check("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one op at the next falling edge; n = CALC cycles (0 for specials).
    // hold keeps valid high while stalled, as a stalled pipeline would.
    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] e, input int n, input bit hold);
        int stalls;
        bit seen;
        exp_t x;
        @(negedge clk);
        op = o; src1 = a; src2 = b; valid = 1'b1;
        x.val = e;
        x.due = cyc + n + 1;
        sbq.push_back(x);
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < n + 10 && !seen; c++) begin
            #1;
            if (stall) stalls++;
            if (result_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                if (!hold) begin
                    valid = 1'b0;
                    // operands must be ignored after accept
                    src1 = ~a; src2 = ~b; op = DIVU;
                end
            end
        end
        valid = 1'b0;
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: op %0d no result within %0d cycles", o, n + 10);
        end
        check("stall_cycles", 64'(stalls), 64'(n + 1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", {63'b0, stall}, 64'd0);
        check("reset_valid", {63'b0, result_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic multiply / divide
        run_op(MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1);
        run_op(DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0);
        run_op(REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run_op(DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run_op(DIVU,  64'd100, 64'd7, 64'd14, 64, 1'b0);
        run_op(REMU,  64'd100, 64'd7, 64'd2, 64, 1'b0);

        // Special cases: accept then DONE, one stall cycle
        run_op(DIV,   64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        run_op(REMU,  64'd5, 64'd0, 64'd5, 0, 1'b1);
        run_op(DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1'b1);
        run_op(REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b1);
        run_op(DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);

        // W-ops
        run_op(MULW,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 1'b1);
        run_op(DIVUW, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b0);
        run_op(REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b0);

        // High-half multiplies and reserved op
        run_op(MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64, 1'b0);
        run_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run_op(MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b0);
        run_op(4'd13,  64'd3, 64'd5, 64'd15, 64, 1'b0);

        // Flush at CALC cycle 10: stall drops at once, no pulse
        @(negedge clk);
        op = DIV; src1 = 64'd1000; src2 = 64'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("precheck_calc_stall", {63'b0, stall}, 64'd1);
        flush = 1'b1;
        #1;
        check("flush_calc_stall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("after_flush_idle_stall", {63'b0, stall}, 64'd0);
        repeat (70) @(negedge clk);
        run_op(MUL, 64'd6, 64'd7, 64'd42, 64, 1'b0);

        // Flush in DONE suppresses the pulse
        @(negedge clk);
        op = DIV; src1 = 64'd9; src2 = 64'd0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_done_valid", {63'b0, result_valid}, 64'd0);
        @(negedge clk);
        flush = 1'b0;

        // Reset mid-CALC clears outputs immediately
        @(negedge clk);
        op = MUL; src1 = 64'd5; src2 = 64'd6; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_calc_stall", {63'b0, stall}, 64'd0);
        check("rst_calc_valid", {63'b0, result_valid}, 64'd0);
        check("rst_calc_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: MUL then DIV in the cycle after DONE
        run_op(MUL, 64'd11, 64'd13, 64'd143, 64, 1'b1);
        run_op(DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
